// File: rtl/unstacker_arbiter.sv
// Round-robin, block-granular arbiter that shares one 128-bit-in / 32-bit-out
// unstacker among N_REQ block producers and tags the word stream with the source ID.
module unstacker_arbiter #(
  parameter int N_REQ       = 2,
  parameter int BLOCK_WORDS = 4,
  parameter int ID_W        = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   enable_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*128-1:0]   req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   unstk_valid_o,
  output logic [127:0]           unstk_data_o,
  input  logic                   unstk_ready_i,
  input  logic                   word_valid_i,
  input  logic                   word_ready_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [ID_W-1:0]        src_id_o,
  output logic                   busy_o,
  output logic [15:0]            blocks_done_o
);

  localparam int              CNT_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ID_W-1:0]  PTR_INIT  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   src_id_q, src_id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       blocks_done_q, blocks_done_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  // Lowest valid index overall is the wrap-around candidate; any valid index
  // above the last grant overrides it. Descending loops leave the lowest match.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pick_found = 1'b0;
    pick_id    = '0;
    for (int r = N_REQ - 1; r >= 0; r--) begin
      if (req_valid_i[r]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(r);
      end
    end
    for (int r = N_REQ - 1; r >= 0; r--) begin
      if (req_valid_i[r] && (ID_W'(r) > last_q)) begin
        pick_id = ID_W'(r);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    src_id_d      = src_id_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    blocks_done_d = blocks_done_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d  = N_REQ'(1) << pick_id;
          src_id_d = pick_id;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (unstk_ready_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (word_valid_i && word_ready_i) begin
          if (cnt_q == LAST_WORD) begin
            state_d       = IDLE;
            last_d        = src_id_q;
            grant_d       = '0;
            cnt_d         = '0;
            blocks_done_d = blocks_done_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i || clr_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      src_id_q      <= '0;
      last_q        <= PTR_INIT;
      cnt_q         <= '0;
      blocks_done_q <= '0;
    end else if (enable_i) begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      src_id_q      <= src_id_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  always_comb begin
    unstk_data_o = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_q[r]) unstk_data_o = unstk_data_o | req_data_i[r*128 +: 128];
    end
  end

  assign unstk_valid_o = (state_q == SEND);
  assign req_ready_o   = (state_q == SEND && enable_i && unstk_ready_i) ? grant_q : '0;
  assign grant_o       = grant_q;
  assign src_id_o      = src_id_q;
  assign busy_o        = (state_q != IDLE);
  assign blocks_done_o = blocks_done_q;

  // The granted producer must hold its block until it is accepted.
  a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
    (enable_i && state_q == SEND) |-> |(req_valid_i & grant_q));

  // Word beats are only meaningful while a block drains.
  a_no_stray_beat : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
    (enable_i && state_q != DRAIN) |-> !(word_valid_i && word_ready_i));

endmodule

// File: tb/tb_unstacker_arbiter.sv
// Self-checking bench for unstacker_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin reference model.
`timescale 1ns/1ps
module tb_unstacker_arbiter;
  localparam int N   = 2;
  localparam int BW  = 4;
  localparam int IDW = 1;

  logic              clk_i = 1'b0;
  logic              rst_i, clr_i, enable_i;
  logic [N-1:0]      req_valid_i;
  logic [N*128-1:0]  req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              unstk_valid_o;
  logic [127:0]      unstk_data_o;
  logic              unstk_ready_i, word_valid_i, word_ready_i;
  logic [N-1:0]      grant_o;
  logic [IDW-1:0]    src_id_o;
  logic              busy_o;
  logic [15:0]       blocks_done_o;

  logic [127:0]      blk [N];
  int                total = 0;
  int                bad   = 0;
  int                m_last, m_done;

  always #5 clk_i = ~clk_i;
  assign req_data_i = {blk[1], blk[0]};

  unstacker_arbiter #(.N_REQ(N), .BLOCK_WORDS(BW), .ID_W(IDW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .unstk_valid_o(unstk_valid_o), .unstk_data_o(unstk_data_o), .unstk_ready_i(unstk_ready_i),
    .word_valid_i(word_valid_i), .word_ready_i(word_ready_i), .grant_o(grant_o),
    .src_id_o(src_id_o), .busy_o(busy_o), .blocks_done_o(blocks_done_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Winner is the valid requester at the smallest circular distance past the last grant.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = N + 1;
    for (int r = 0; r < N; r++) begin
      if (v[r]) begin
        d = (r - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = r;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Serves one block from IDLE: grant, optional SEND stall, hand-off, then word beats.
  task automatic serve_block(input int stall, input bit keep, input bit rnd,
                             input logic [15:0] pat, input int abort_at,
                             input int freeze_at, output int g);
    logic [N-1:0] g_vec;
    int           counted, k;
    bit           froze, beat;
    g      = rr_pick(req_valid_i, m_last);
    g_vec  = N'(1) << g;
    froze  = 1'b0;
    unstk_ready_i = 1'b0;
    cyc(); #1;
    total++; if (grant_o !== g_vec) begin bad++; $display("FAIL grant got=%b exp=%b", grant_o, g_vec); end
    total++; if (src_id_o !== IDW'(g)) begin bad++; $display("FAIL src_id got=%0d exp=%0d", src_id_o, g); end
    total++; if (unstk_valid_o !== 1'b1) begin bad++; $display("FAIL send_valid got=%b exp=1", unstk_valid_o); end
    total++; if (unstk_data_o !== blk[g]) begin bad++; $display("FAIL send_data got=%h exp=%h", unstk_data_o, blk[g]); end
    for (int s = 0; s < stall; s++) begin
      total++;
      if (req_ready_o !== '0 || unstk_valid_o !== 1'b1 || unstk_data_o !== blk[g]) begin
        bad++; $display("FAIL send_hold cyc=%0d ready=%b valid=%b data=%h exp ready=0 valid=1 data=%h",
                        s, req_ready_o, unstk_valid_o, unstk_data_o, blk[g]);
      end
      cyc();
    end
    unstk_ready_i = 1'b1;
    #1;
    total++; if (req_ready_o !== g_vec) begin bad++; $display("FAIL req_ready got=%b exp=%b", req_ready_o, g_vec); end
    cyc();
    unstk_ready_i = 1'b0;
    if (keep) blk[g] = rnd_blk();
    else req_valid_i[g] = 1'b0;
    #1;
    total++;
    if (unstk_valid_o !== 1'b0 || req_ready_o !== '0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL drain_entry valid=%b ready=%b busy=%b exp valid=0 ready=0 busy=1",
                      unstk_valid_o, req_ready_o, busy_o);
    end
    counted = 0;
    k       = 0;
    while (counted < BW) begin
      if (k > 300) begin
        total++; bad++; $display("FAIL drain_timeout counted=%0d exp=%0d", counted, BW);
        break;
      end
      if (abort_at >= 0 && counted == abort_at) begin
        clr_i = 1'b1; word_valid_i = 1'b0; word_ready_i = 1'b0;
        cyc();
        clr_i = 1'b0;
        #1;
        m_last = N - 1;
        m_done = 0;
        total++;
        if (busy_o !== 1'b0 || grant_o !== '0 || blocks_done_o !== 16'd0 || src_id_o !== '0) begin
          bad++; $display("FAIL abort busy=%b grant=%b done=%0d src=%0d exp 0,0,0,0",
                          busy_o, grant_o, blocks_done_o, src_id_o);
        end
        return;
      end
      if (freeze_at >= 0 && counted == freeze_at && !froze) begin
        froze = 1'b1;
        enable_i = 1'b0; word_valid_i = 1'b1; word_ready_i = 1'b1;
        repeat (3) cyc();
        #1;
        total++;
        if (busy_o !== 1'b1 || grant_o !== g_vec || blocks_done_o !== 16'(m_done)) begin
          bad++; $display("FAIL freeze busy=%b grant=%b done=%0d exp busy=1 grant=%b done=%0d",
                          busy_o, grant_o, blocks_done_o, g_vec, m_done);
        end
        enable_i = 1'b1;
      end
      if (rnd) begin
        word_valid_i = 1'($urandom_range(0, 1));
        word_ready_i = 1'($urandom_range(0, 1));
      end else begin
        word_valid_i = 1'b1;
        word_ready_i = pat[k % 16];
      end
      beat = word_valid_i & word_ready_i;
      cyc();
      k++;
      if (beat) counted++;
      #1;
      if (counted < BW) begin
        total++;
        if (busy_o !== 1'b1 || grant_o !== g_vec || unstk_valid_o !== 1'b0) begin
          bad++; $display("FAIL drain_hold beat=%0d busy=%b grant=%b valid=%b exp busy=1 grant=%b valid=0",
                          counted, busy_o, grant_o, unstk_valid_o, g_vec);
        end
      end
    end
    word_valid_i = 1'b0;
    word_ready_i = 1'b0;
    m_last = g;
    m_done = (m_done + 1) % 65536;
    total++;
    if (busy_o !== 1'b0 || grant_o !== '0 || src_id_o !== IDW'(g) || blocks_done_o !== 16'(m_done)) begin
      bad++; $display("FAIL drain_exit busy=%b grant=%b src=%0d done=%0d exp busy=0 grant=0 src=%0d done=%0d",
                      busy_o, grant_o, src_id_o, blocks_done_o, g, m_done);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clr_i = 1'b0; enable_i = 1'b1;
    req_valid_i = '0; unstk_ready_i = 1'b0; word_valid_i = 1'b0; word_ready_i = 1'b0;
    blk[0] = '0; blk[1] = '0;
    repeat (2) cyc();
    rst_i = 1'b0;
    #1;
    m_last = N - 1;
    m_done = 0;
    total++;
    if (busy_o !== 1'b0 || grant_o !== '0 || src_id_o !== '0 || unstk_valid_o !== 1'b0 ||
        blocks_done_o !== 16'd0 || req_ready_o !== '0) begin
      bad++; $display("FAIL reset busy=%b grant=%b src=%0d valid=%b done=%0d ready=%b exp all zero",
                      busy_o, grant_o, src_id_o, unstk_valid_o, blocks_done_o, req_ready_o);
    end
  endtask

  task automatic test_single();
    int g;
    test_reset();
    blk[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    req_valid_i = 2'b01;
    #1;
    total++;
    if (unstk_valid_o !== 1'b0 || req_ready_o !== '0) begin
      bad++; $display("FAIL single_pre valid=%b ready=%b exp 0,0", unstk_valid_o, req_ready_o);
    end
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
    total++; if (blocks_done_o !== 16'd1) begin bad++; $display("FAIL single_done got=%0d exp=1", blocks_done_o); end
  endtask

  task automatic test_contention();
    int g;
    int exp_order [4] = '{0, 1, 0, 1};
    test_reset();
    blk[0] = rnd_blk(); blk[1] = rnd_blk();
    req_valid_i = 2'b11;
    for (int b = 0; b < 4; b++) begin
      serve_block(0, 1'b1, 1'b0, 16'hFFFF, -1, -1, g);
      total++; if (g != exp_order[b]) begin bad++; $display("FAIL contention_order blk=%0d got=%0d exp=%0d", b, g, exp_order[b]); end
    end
    req_valid_i = '0;
    total++; if (blocks_done_o !== 16'd4) begin bad++; $display("FAIL contention_done got=%0d exp=4", blocks_done_o); end
  endtask

  task automatic test_backpressure();
    int g;
    test_reset();
    blk[1] = rnd_blk();
    req_valid_i = 2'b10;
    serve_block(5, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
  endtask

  task automatic test_drain_stall();
    int g;
    test_reset();
    blk[0] = rnd_blk(); blk[1] = rnd_blk();
    req_valid_i = 2'b11;
    serve_block(0, 1'b0, 1'b0, 16'b0000_0000_0101_1001 | 16'h0020 ^ 16'h0020, -1, -1, g);
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
    total++; if (g != 1) begin bad++; $display("FAIL stall_next_grant got=%0d exp=1", g); end
  endtask

  task automatic test_abort();
    int g;
    test_reset();
    blk[0] = rnd_blk(); blk[1] = rnd_blk();
    req_valid_i = 2'b01;
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
    req_valid_i = 2'b01;
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, 2, -1, g);
    req_valid_i = 2'b11;
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
    total++; if (g != 0) begin bad++; $display("FAIL abort_regrant got=%0d exp=0", g); end
    req_valid_i = '0;
  endtask

  task automatic test_freeze_wrap();
    int g;
    test_reset();
    blk[0] = rnd_blk();
    req_valid_i = 2'b01;
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, 2, g);
    dut.blocks_done_q = 16'hFFFF;
    m_done = 65535;
    req_valid_i = 2'b01;
    serve_block(0, 1'b0, 1'b0, 16'hFFFF, -1, -1, g);
    total++; if (blocks_done_o !== 16'd0) begin bad++; $display("FAIL wrap got=%0d exp=0", blocks_done_o); end
  endtask

  task automatic test_random();
    int g;
    test_reset();
    for (int it = 0; it < 40; it++) begin
      blk[0] = rnd_blk(); blk[1] = rnd_blk();
      req_valid_i = N'($urandom_range(1, 3));
      serve_block($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 16'hFFFF, -1, -1, g);
    end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain_stall();
    test_abort();
    test_freeze_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unstacker_arbiter.md
Name: unstacker_arbiter

Overview:
- Shares the single 128-bit-in / 32-bit-out unstacker among N_REQ 128-bit block producers, e.g. the AES encrypt and decrypt result paths.
- Uses round-robin arbitration at block granularity.
- Holds a grant until the unstacker has emitted all BLOCK_WORDS 32-bit words of the granted block. Output words therefore never interleave between requesters.
- Tags the word stream with the source ID for the downstream streamer.

Parameters:
- N_REQ, 2, number of 128-bit requesters (2..8).
- BLOCK_WORDS, 4, 32-bit words the unstacker emits per 128-bit block.
- ID_W, 1, width of source ID; must be at least $clog2(N_REQ).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- clr_i  in  1  synchronous soft clear; same effect as rst_i.
- enable_i  in  1  0 = freeze all state; outputs hold their registered values.
- req_valid_i  in  N_REQ  per-requester block valid.
- req_data_i  in  N_REQ*128  requester r's block is at bits [r*128 +: 128].
- req_ready_o  out  N_REQ  per-requester accept, one-hot or zero.
- unstk_valid_o  out  1  block valid to the unstacker.
- unstk_data_o  out  128  block to the unstacker.
- unstk_ready_i  in  1  unstacker input ready.
- word_valid_i  in  1  unstacker output word valid (monitored).
- word_ready_i  in  1  downstream ready for the unstacker output word (monitored).
- grant_o  out  N_REQ  one-hot current grant; 0 when IDLE.
- src_id_o  out  ID_W  index of the granted requester; tags the word stream.
- busy_o  out  1  high in any state except IDLE.
- blocks_done_o  out  16  count of fully drained blocks; wraps at 65535 to 0.

Behaviour:
- Reset and clr_i values:
  - state=IDLE, grant_o=0, src_id_o=0, busy_o=0, unstk_valid_o=0, blocks_done_o=0, word counter=0.
  - last-grant pointer = N_REQ-1, so requester 0 has first priority.
  - rst_i or clr_i mid-operation aborts the block immediately. No ready is issued for it, and the unstacker must be cleared by the same clr_i.
- Priority: rst_i > clr_i > enable_i=0 (hold) > normal operation.
- FSM states are IDLE, SEND and DRAIN.
- IDLE:
  - If any req_valid_i is set, pick the first set bit scanning from (last+1) mod N_REQ upward with wrap.
  - Register grant_o and src_id_o, then go to SEND.
  - Request-to-unstk_valid_o latency is 1 cycle.
  - With no request, stay in IDLE.
- SEND:
  - unstk_valid_o=1; unstk_data_o = granted requester's data, muxed combinationally from the registered grant.
  - req_ready_o[g] = unstk_ready_i (combinational pass-through). All other ready bits are 0.
  - When unstk_ready_i=1, the transfer occurs: go to DRAIN, word counter=0.
  - If the granted requester drops valid while in SEND, that is a protocol violation. Behaviour is undefined; an assertion flags it.
- DRAIN:
  - unstk_valid_o=0.
  - Each cycle with word_valid_i & word_ready_i increments the word counter.
  - On the beat where counter==BLOCK_WORDS-1: go to IDLE, last=g, grant_o=0, blocks_done_o+1.
  - src_id_o holds g until the next grant.
- Back-to-back: the next arbitration starts in IDLE the cycle after the last drained word. The gap between blocks is therefore 1 IDLE cycle plus 1 SEND cycle minimum.
- Simultaneous requests: only round-robin order decides. A requester that stays valid never waits more than N_REQ-1 blocks.
- Word-counter width is $clog2(BLOCK_WORDS). It never wraps, because it resets on each DRAIN exit.
- Beats seen in IDLE or SEND are ignored; an assertion flags them.
- req_ready_o is never asserted outside SEND.
- enable_i=0: no state change. Handshakes with enable_i low are not counted, and both readies are forced to 0.

Test Plan:
- Single requester: req_valid_i=01, data=0x00112233_44556677_8899AABB_CCDDEEFF, unstk_ready_i=1, 4 word beats -> unstk_valid_o rises 1 cycle after the request; req_ready_o=01 for exactly 1 cycle; src_id_o=0; blocks_done_o=1; busy_o falls after the 4th beat.
- Contention: both requesters valid continuously for 4 blocks -> grant order 0,1,0,1; blocks_done_o=4; grant_o never changes during DRAIN.
- Backpressure: unstk_ready_i=0 for 5 cycles in SEND -> unstk_valid_o and data stable; req_ready_o=0; the transfer completes on the first cycle with unstk_ready_i=1.
- Drain stall: word_ready_i toggling 1,0,0,1,1,0,1 -> exit DRAIN only on the 4th counted beat; a request from requester 1 waiting during this time is not granted early.
- Abort: clr_i asserted after 2 drained words -> next cycle state=IDLE, grant_o=0, pointer reset, blocks_done_o=0; the next simultaneous request grants requester 0.
- Freeze and wrap: enable_i=0 for 3 cycles mid-DRAIN with beats present -> counter unchanged. Separately, preload 65535 blocks and drain one more -> blocks_done_o=0.
